// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and mask-width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic int calc_mask_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NUM_CH.
module rr_pick #(
  parameter  int NUM_CH = 2,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic              valid,
  output logic [IDX_W-1:0]  grant
);

  // Scan from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_CH]) begin
        valid = 1'b1;
        grant = IDX_W'((int'(last) + k) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel round-robin arbiter merging CPU-side memory ports onto one memory port.
// Define MEM_ARB_RDATA_REG_EN to register the response path (adds the RESP state).
//
//   state | meaning
//   IDLE  | no transaction; arbitrate among pending requests
//   BUSY  | granted request driven to memory, waiting for mem_resp
//   RESP  | (registered-rdata build only) returning captured rdata to the winner
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = 16,
  localparam int MASK_W = calc_mask_w(DATA_W),
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*MASK_W-1:0] ch_wmask,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [MASK_W-1:0]        mem_wmask,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_resp,
  input  logic [DATA_W-1:0]        mem_rdata
);

  arb_state_t        state_q, state_d;
  // grant_q doubles as last_grant: it is only replaced by a new winner.
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  int                sel;
  logic              busy;
  logic              resp_fire;

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req   (ch_read | ch_write),
    .last  (grant_q),
    .valid (pick_valid),
    .grant (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    sel     = int'(pick_idx);
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          grant_d = pick_idx;
          op_wr_d = ch_write[sel];
          addr_d  = ch_address[sel*ADDR_W +: ADDR_W];
          wdata_d = ch_wdata[sel*DATA_W +: DATA_W];
          wmask_d = ch_wmask[sel*MASK_W +: MASK_W];
        end
      end
      BUSY: begin
        if (mem_resp) begin
`ifdef MEM_ARB_RDATA_REG_EN
          state_d = RESP;
`else
          state_d = IDLE;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= IDX_W'(NUM_CH - 1);
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign busy        = (state_q == BUSY);
  assign mem_read    = busy & ~op_wr_q;
  assign mem_write   = busy & op_wr_q;
  assign mem_wmask   = busy ? wmask_q : '0;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

`ifdef MEM_ARB_RDATA_REG_EN
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (busy && mem_resp) rdata_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign resp_fire = (state_q == RESP);
  assign ch_rdata  = resp_fire ? rdata_q : '0;
`else
  assign resp_fire = busy & mem_resp;
  assign ch_rdata  = resp_fire ? mem_rdata : '0;
`endif

  always_comb begin
    ch_resp = '0;
    if (resp_fire) ch_resp[grant_q] = 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (4 channels, 16-bit address/data).
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 2;
`ifdef MEM_ARB_RDATA_REG_EN
  localparam int RL = 1;
`else
  localparam int RL = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    ch_read, ch_write;
  logic [N*MW-1:0] ch_wmask;
  logic [N*AW-1:0] ch_address;
  logic [N*DW-1:0] ch_wdata;
  logic [N-1:0]    ch_resp;
  logic [DW-1:0]   ch_rdata;
  logic            mem_read, mem_write;
  logic [MW-1:0]   mem_wmask;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_wdata;
  logic            mem_resp;
  logic [DW-1:0]   mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_read(ch_read), .ch_write(ch_write), .ch_wmask(ch_wmask),
    .ch_address(ch_address), .ch_wdata(ch_wdata),
    .ch_resp(ch_resp), .ch_rdata(ch_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  task automatic clear_inputs();
    ch_read = '0; ch_write = '0; ch_wmask = '0;
    ch_address = '0; ch_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
  endtask

  // Leaves the bench at a negedge with reset released; the next posedge is the first active one.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int c, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    ch_read[c] = rd;
    ch_write[c] = wr;
    ch_address[c*AW +: AW] = a;
    ch_wdata[c*DW +: DW] = d;
    ch_wmask[c*MW +: MW] = m;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ch_read = 4'b0011; mem_resp = 1'b1; mem_rdata = 16'hFFFF;
    #1;
    checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); end
    checks++; if (mem_wmask !== '0) begin errors++; $display("FAIL reset_wmask got=%h exp=0", mem_wmask); end
    checks++; if (mem_address !== '0) begin errors++; $display("FAIL reset_address got=%h exp=0", mem_address); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    checks++; if (ch_resp !== '0) begin errors++; $display("FAIL reset_ch_resp got=%b exp=0", ch_resp); end
    checks++; if (ch_rdata !== '0) begin errors++; $display("FAIL reset_ch_rdata got=%h exp=0", ch_rdata); end
    clear_inputs();
  endtask

  // Cycle i=0 is the IDLE cycle that sees the request; mem_resp is driven at i=3.
  task automatic test_single_read();
    int rc;
    logic exp_mr;
    logic [AW-1:0] exp_a;
    logic [N-1:0] exp_r;
    rc = 3 + RL;
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h1234, 16'h0, 2'b00);
    set_req(1, 1'b0, 1'b0, 16'h5678, 16'h0, 2'b00);
    for (int i = 0; i <= rc + 2; i++) begin
      if (i > 0) @(negedge clk);
      ch_read[0] = (i <= rc);
      ch_read[1] = (i > rc);
      mem_resp   = (i == 3);
      mem_rdata  = (i == 3) ? 16'hBEEF : 16'h0000;
      #1;
      exp_mr = (i >= 1 && i <= 3) || (i == rc + 2);
      exp_a  = (i == rc + 2) ? 16'h5678 : 16'h1234;
      exp_r  = (i == rc) ? 4'b0001 : 4'b0000;
      checks++; if (mem_read !== exp_mr) begin errors++; $display("FAIL single_mem_read i=%0d got=%b exp=%b", i, mem_read, exp_mr); end
      if (exp_mr) begin
        checks++; if (mem_address !== exp_a) begin errors++; $display("FAIL single_address i=%0d got=%h exp=%h", i, mem_address, exp_a); end
      end
      checks++; if (ch_resp !== exp_r) begin errors++; $display("FAIL single_ch_resp i=%0d got=%b exp=%b", i, ch_resp, exp_r); end
      if (i == rc) begin
        checks++; if (ch_rdata !== 16'hBEEF) begin errors++; $display("FAIL single_rdata got=%h exp=BEEF", ch_rdata); end
      end
    end
  endtask

  task automatic test_write_mask();
    do_reset();
    set_req(1, 1'b0, 1'b1, 16'h0042, 16'hA500, 2'b10);
    @(negedge clk); #1;
    checks++; if ({mem_read, mem_write} !== 2'b01) begin errors++; $display("FAIL wr_strobes got=%b exp=01", {mem_read, mem_write}); end
    checks++; if (mem_wmask !== 2'b10) begin errors++; $display("FAIL wr_wmask got=%b exp=10", mem_wmask); end
    checks++; if (mem_wdata !== 16'hA500) begin errors++; $display("FAIL wr_wdata got=%h exp=A500", mem_wdata); end
    checks++; if (mem_address !== 16'h0042) begin errors++; $display("FAIL wr_address got=%h exp=0042", mem_address); end
  endtask

  task automatic test_rd_wr_same();
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'h0777, 16'h1357, 2'b11);
    @(negedge clk); #1;
    checks++; if ({mem_read, mem_write} !== 2'b01) begin errors++; $display("FAIL rdwr_strobes got=%b exp=01", {mem_read, mem_write}); end
  endtask

  task automatic test_contention();
    int n, bc;
    logic [N-1:0] exp_r;
    logic [DW-1:0] exp_d;
    do_reset();
    for (int c = 0; c < N; c++) set_req(c, 1'b1, 1'b0, AW'(16'h0100 * c), 16'h0, 2'b00);
    n = 0; bc = 0;
    for (int cyc = 0; cyc < 200 && n < 8; cyc++) begin
      @(negedge clk); #1;
      if (mem_read) begin mem_resp = (bc == 1); bc++; end
      else begin mem_resp = 1'b0; bc = 0; end
      mem_rdata = mem_address ^ 16'h5A5A;
      #1;
      if (ch_resp !== '0) begin
        exp_r = '0; exp_r[n % N] = 1'b1;
        exp_d = DW'(16'h0100 * (n % N)) ^ 16'h5A5A;
        checks++; if (ch_resp !== exp_r) begin errors++; $display("FAIL cont_order n=%0d got=%b exp=%b", n, ch_resp, exp_r); end
        checks++; if (ch_rdata !== exp_d) begin errors++; $display("FAIL cont_rdata n=%0d got=%h exp=%h", n, ch_rdata, exp_d); end
        n++;
      end
    end
    checks++; if (n < 8) begin errors++; $display("FAIL cont_timeout got=%0d exp=8 responses", n); end
    mem_resp = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h1111, 16'h0, 2'b00);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL rstmid_strobes got=%b exp=00", {mem_read, mem_write}); end
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    checks++; if (ch_resp !== '0) begin errors++; $display("FAIL rstmid_ch_resp got=%b exp=0", ch_resp); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'h2000, 16'h0, 2'b00);
    set_req(1, 1'b1, 1'b0, 16'h3000, 16'h0, 2'b00);
    @(negedge clk); #1;
    checks++; if (mem_read !== 1'b1 || mem_address !== 16'h2000) begin errors++; $display("FAIL rstmid_first_grant got=%b/%h exp=1/2000", mem_read, mem_address); end
  endtask

  task automatic new_req(input int c);
    int r;
    r = $urandom_range(0, 3);
    set_req(c, (r != 2), (r >= 2), AW'($urandom), DW'($urandom), MW'($urandom));
  endtask

  // Reference: phase 0 idle, 1 memory access outstanding, 2 registered response.
  task automatic test_random();
    int phase, m_last, m_g, dly, c;
    logic e_wr, fire;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata, exp_d;
    logic [MW-1:0] e_wmask;
    logic [N-1:0] exp_r;
    do_reset();
    phase = 0; m_last = N - 1; m_g = 0; dly = 0;
    e_wr = 0; e_addr = '0; e_wdata = '0; e_wmask = '0; e_rdata = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (phase == 1) begin
        mem_resp = (dly == 0);
        mem_rdata = DW'($urandom);
        if (dly > 0) dly--;
      end else if (phase == 0) begin
        mem_resp = ($urandom_range(0, 7) == 0);
        mem_rdata = DW'($urandom);
      end else begin
        mem_resp = 1'b0;
      end
      #1;
      fire = (phase == 1 && mem_resp && RL == 0) || (phase == 2);
      exp_r = '0;
      if (fire) exp_r[m_g] = 1'b1;
      exp_d = (phase == 2) ? e_rdata : mem_rdata;
      checks++; if (ch_resp !== exp_r) begin errors++; $display("FAIL rnd_ch_resp cyc=%0d got=%b exp=%b", cyc, ch_resp, exp_r); end
      if (fire) begin
        checks++; if (ch_rdata !== exp_d) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, ch_rdata, exp_d); end
      end
      if (phase == 1) begin
        checks++;
        if ({mem_read, mem_write} !== {~e_wr, e_wr} || mem_address !== e_addr ||
            mem_wdata !== e_wdata || mem_wmask !== e_wmask) begin
          errors++;
          $display("FAIL rnd_mem cyc=%0d got=%b%b/%h/%h/%b exp=%b%b/%h/%h/%b", cyc,
                   mem_read, mem_write, mem_address, mem_wdata, mem_wmask,
                   ~e_wr, e_wr, e_addr, e_wdata, e_wmask);
        end
      end else if (phase == 0) begin
        checks++;
        if ({mem_read, mem_write} !== 2'b00 || mem_wmask !== '0) begin
          errors++; $display("FAIL rnd_idle cyc=%0d got=%b%b/%b exp=00/0", cyc, mem_read, mem_write, mem_wmask);
        end
      end
      for (int k = 0; k < N; k++) begin
        if (fire && k == m_g) begin
          if ($urandom_range(0, 1) == 1) new_req(k);
          else begin ch_read[k] = 1'b0; ch_write[k] = 1'b0; end
        end else if (!(ch_read[k] | ch_write[k]) && $urandom_range(0, 3) == 0) begin
          new_req(k);
        end
      end
      if (phase == 1) begin
        if (mem_resp) begin
          e_rdata = mem_rdata;
          phase = (RL == 1) ? 2 : 0;
        end
      end else if (phase == 2) begin
        phase = 0;
      end else if ((ch_read | ch_write) != '0) begin
        for (int k = N; k >= 1; k--) begin
          c = (m_last + k) % N;
          if (ch_read[c] | ch_write[c]) m_g = c;
        end
        m_last  = m_g;
        e_wr    = ch_write[m_g];
        e_addr  = ch_address[m_g*AW +: AW];
        e_wdata = ch_wdata[m_g*DW +: DW];
        e_wmask = ch_wmask[m_g*MW +: MW];
        dly     = $urandom_range(0, 3);
        phase   = 1;
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_mask();
    test_rd_wr_same();
    test_contention();
    test_reset_mid_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter. Merges NUM_CH CPU-side memory ports (read/write/wmask/address/wdata/resp/rdata handshake) onto one physical memory port.
- Generalises the two-port (instruction/data) CPU boundary: any channel count, address width and data width, with round-robin fairness.
- Sits between the cpu and a single-ported memory or L2 controller.

Parameters:
- NUM_CH, 2, number of requesting channels (≥2)
- ADDR_W, 16, address width
- DATA_W, 16, data width (multiple of 8)
- MASK_W, DATA_W/8, byte write-mask width (derived; not overridden)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ch_read  input  NUM_CH  per-channel read request
- ch_write  input  NUM_CH  per-channel write request
- ch_wmask  input  NUM_CH*MASK_W  per-channel byte mask, channel i at [i*MASK_W +: MASK_W]
- ch_address  input  NUM_CH*ADDR_W  per-channel address, packed as above
- ch_wdata  input  NUM_CH*DATA_W  per-channel write data, packed as above
- ch_resp  output  NUM_CH  per-channel completion pulse
- ch_rdata  output  DATA_W  read data, broadcast; valid only with the matching ch_resp
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_wmask  output  MASK_W  memory byte mask
- mem_address  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_resp  input  1  memory completion pulse
- mem_rdata  input  DATA_W  memory read data

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Protocol (both sides): requester holds read or write plus address/data stable until resp is seen high for one cycle. After resp, the requester drops or replaces the request on the next cycle.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any ch_read|ch_write is set, pick the winner by round-robin. Search starts at last_grant+1 and wraps modulo NUM_CH.
  - Register grant, op (write if ch_write, else read), address, wdata and wmask. Update last_grant. Next state is BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mem_read/mem_write driven from registered op. mem_address/wdata/wmask driven from the latched copies.
  - On mem_resp: ch_resp[grant]=1 combinationally in the same cycle, ch_rdata=mem_rdata. Next state is IDLE.
  - Without mem_resp: stay in BUSY indefinitely (no timeout).
- Latency:
  - Request visible in IDLE at cycle t → mem strobe at t+1.
  - Minimum turnaround: 2 cycles per transaction. Back-to-back grants are separated by one IDLE cycle.
- Fairness: a channel that just completed has lowest priority in the next arbitration. Every requester is served within NUM_CH transactions.
- Simultaneous ch_read and ch_write on one channel: illegal. Write wins; read is ignored for that transaction.
- Request changes in BUSY: request lines of the granted channel are not re-sampled. Changes by other channels have no effect until IDLE.
- Outputs in IDLE: mem_read=mem_write=0, ch_resp=0, mem_wmask=0. mem_address/wdata hold last value (don't-care).
- mem_resp in IDLE: ignored, no ch_resp.
- Reset (any time, including mid-transaction):
  - State IDLE, last_grant=NUM_CH-1 (channel 0 has first priority), mem_read=mem_write=0, mem_wmask=0, mem_address=0, mem_wdata=0, ch_resp=0, ch_rdata=0.
  - An in-flight transaction is abandoned. No ch_resp is issued for it.

Optional Feature:
- MEM_ARB_RDATA_REG_EN defined:
  - Adds state RESP. BUSY+mem_resp → RESP. In RESP, ch_resp[grant]=1 and ch_rdata come from registers (captured mem_rdata). RESP → IDLE.
  - Minimum turnaround becomes 3 cycles. Removes the mem_rdata→ch_rdata combinational path.
- Undefined: combinational pass-through as above.

Decomposition:
- Package mem_arb_pkg: arb_state_t enum (IDLE, BUSY, RESP) and a function computing MASK_W from DATA_W.
- Sub-module rr_pick: combinational round-robin picker.
  - Parameter NUM_CH.
  - Inputs req[NUM_CH], last[$clog2(NUM_CH)].
  - Outputs valid, grant index.

Test Plan:
- Single read, NUM_CH=2: ch_read=2'b01, ch_address[0]=16'h1234, mem_resp one cycle at t+3 with mem_rdata=16'hBEEF → mem_read=1, mem_address=16'h1234 from t+1; ch_resp=2'b01 and ch_rdata=16'hBEEF at t+3; mem_read=0 at t+4.
- Contention, NUM_CH=4: all four channels read continuously, each mem_resp after 1 cycle → grant order 0,1,2,3,0; each ch_resp exactly once per 4 transactions.
- Write mask: ch_write[1]=1, wmask=2'b10, wdata=16'hA500, address=16'h0042 → mem_write=1, mem_wmask=2'b10, mem_wdata=16'hA500, mem_address=16'h0042; mem_read stays 0.
- Read+write same channel: ch_read[0]=ch_write[0]=1 → only mem_write asserted.
- Reset mid-BUSY: assert rst_n=0 two cycles after grant, before mem_resp → mem_read/mem_write drop asynchronously; no ch_resp; after release, first grant goes to channel 0 when channels 0 and 1 both request.
- MEM_ARB_RDATA_REG_EN: repeat the single-read case → ch_resp and ch_rdata=16'hBEEF arrive at t+4, not t+3; next grant no earlier than t+6.
